mod_147_tx_heartbeat: RTL and testbench

Transmit-side heartbeat generator for the 10BASE-T1S point-to-point link status function. While auto-negotiation has brought up a non-multidrop link, it emits HEARTBEAT on the PCS tx_cmd path whenever the transmitter has been quiet for HB_INTERVAL cycles. The link partner's link-status monitor counts these heartbeats to reach and hold pcs_status = OK. The block sits between the PLCA/MAC transmit path and PCS transmit, and merges PLCA commands with the heartbeat.

---
 rtl/mod_147_tx_heartbeat_pkg.sv | 30 +++
 rtl/mod_147_tx_hb_timer.sv | 32 +++
 rtl/mod_147_tx_heartbeat.sv | 130 +++++++++++++
 tb/tb_mod_147_tx_heartbeat.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_147_tx_heartbeat_pkg.sv
// Shared encodings for the 10BASE-T1S transmit heartbeat generator:
// PCS command codes, generator states, link-status values.
package mod_147_tx_heartbeat_pkg;

   typedef enum logic [1:0] {
      CMD_BEACON    = 2'b00,
      CMD_COMMIT    = 2'b01,
      CMD_HEARTBEAT = 2'b10,
      CMD_NONE      = 2'b11
   } tx_cmd_t;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'b00,
      ST_WAIT     = 2'b01,
      ST_SEND     = 2'b10,
      ST_GAP      = 2'b11
   } hb_state_t;

   typedef enum logic {
      PCS_NOT_OK = 1'b0,
      PCS_OK     = 1'b1
   } pcs_status_t;

   localparam logic [7:0] HB_COUNT_MAX = 8'd255;

   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      return (value == HB_COUNT_MAX) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/mod_147_tx_hb_timer.sv
// Loadable down-counter shared by the quiet-interval and heartbeat-length
// phases; terminal is high when the count has reached zero.
module mod_147_tx_hb_timer
   import mod_147_tx_heartbeat_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             TX_CLK,
   input  logic             pcs_reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             terminal
);

   logic [CNT_W-1:0] count;

   // NOTE: sequential state is always written with non-blocking (<=) so every
   // flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge TX_CLK or posedge pcs_reset) begin
      if (pcs_reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec) begin
         count <= count - CNT_W'(1);
      end
   end

   assign terminal = (count == '0);

endmodule

// File: rtl/mod_147_tx_heartbeat.sv
// Transmit heartbeat generator: emits HEARTBEAT on tx_cmd after HB_INTERVAL
// quiet cycles on a point-to-point link, merging it with PLCA commands.
module mod_147_tx_heartbeat
   import mod_147_tx_heartbeat_pkg::*;
#(
   parameter logic [15:0] HB_INTERVAL = 16'd1000,
   parameter logic [3:0]  HB_LEN      = 4'd2,
   parameter int          CNT_W       = 16
) (
   input  logic       TX_CLK,
   input  logic       pcs_reset,
   input  logic       mr_autoneg_enable,
   input  logic       an_link_good,
   input  logic       multidrop,
   input  logic       TX_EN,
   input  logic [1:0] tx_cmd_in,
   output logic [1:0] tx_cmd,
   output logic       hb_active,
   output logic [7:0] hb_count,
   output logic [1:0] hb_state
);

   // The timer counts down to zero, so the quiet phase loads INTERVAL-1 and
   // the send phase loads LEN-1; terminal then marks the last cycle of each.
   localparam logic [CNT_W-1:0] QUIET_LOAD = CNT_W'(HB_INTERVAL - 16'd1);
   localparam logic [CNT_W-1:0] LEN_LOAD   = CNT_W'(HB_LEN - 4'd1);

   hb_state_t        state, next_state;
   tx_cmd_t          cmd_in, tx_cmd_q, tx_cmd_next;
   logic             hb_active_next;
   logic             count_inc;
   logic             en, quiet;
   logic             timer_load, timer_dec, timer_done;
   logic [CNT_W-1:0] timer_val;

   // pcs_reset is left out of en: the asynchronous reset branch already wins.
   assign en     = mr_autoneg_enable & an_link_good & ~multidrop;
   assign cmd_in = tx_cmd_t'(tx_cmd_in);
   assign quiet  = ~TX_EN & (cmd_in == CMD_NONE);

   mod_147_tx_hb_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .TX_CLK   (TX_CLK),
      .pcs_reset(pcs_reset),
      .load     (timer_load),
      .load_val (timer_val),
      .dec      (timer_dec),
      .terminal (timer_done)
   );

   // NOTE: every always_comb output gets a default first, so no path through
   // the case statement can leave a signal unassigned and infer a latch.
   always_comb begin
      next_state     = state;
      timer_load     = 1'b0;
      timer_val      = QUIET_LOAD;
      timer_dec      = 1'b0;
      count_inc      = 1'b0;
      tx_cmd_next    = cmd_in;
      hb_active_next = 1'b0;

      if (!en) begin
         next_state = ST_DISABLED;
         timer_load = 1'b1;
      end else begin
         unique case (state)
            ST_DISABLED: begin
               next_state = ST_WAIT;
               timer_load = 1'b1;
            end
            ST_WAIT: begin
               if (!quiet) begin
                  timer_load = 1'b1;
               end else if (timer_done) begin
                  next_state = ST_SEND;
                  timer_load = 1'b1;
                  timer_val  = LEN_LOAD;
                  count_inc  = 1'b1;
               end else begin
                  timer_dec = 1'b1;
               end
            end
            ST_SEND: begin
               // Any activity aborts straight back to WAIT with no gap.
               if (!quiet) begin
                  next_state = ST_WAIT;
                  timer_load = 1'b1;
               end else begin
                  tx_cmd_next    = CMD_HEARTBEAT;
                  hb_active_next = 1'b1;
                  if (timer_done) begin
                     next_state = ST_GAP;
                  end else begin
                     timer_dec = 1'b1;
                  end
               end
            end
            ST_GAP: begin
               next_state  = ST_WAIT;
               timer_load  = 1'b1;
               tx_cmd_next = CMD_NONE;
            end
            default: begin
               next_state = ST_DISABLED;
            end
         endcase
      end
   end

   always_ff @(posedge TX_CLK or posedge pcs_reset) begin
      if (pcs_reset) begin
         state     <= ST_DISABLED;
         tx_cmd_q  <= CMD_NONE;
         hb_active <= 1'b0;
         hb_count  <= '0;
      end else begin
         state     <= next_state;
         tx_cmd_q  <= tx_cmd_next;
         hb_active <= hb_active_next;
         if (count_inc) begin
            hb_count <= sat_inc(hb_count);
         end
      end
   end

   assign tx_cmd   = tx_cmd_q;
   assign hb_state = state;

endmodule

// File: tb/tb_mod_147_tx_heartbeat.sv
// Self-checking bench for mod_147_tx_heartbeat with HB_INTERVAL=8, HB_LEN=2:
// directed scenarios plus random traffic against a cycle-count reference model.
module tb_mod_147_tx_heartbeat;
   import mod_147_tx_heartbeat_pkg::*;

   localparam logic [15:0] HB_INTERVAL = 16'd8;
   localparam logic [3:0]  HB_LEN      = 4'd2;
   localparam int          INTERVAL    = 8;
   localparam int          LEN         = 2;

   logic       TX_CLK = 1'b0;
   logic       pcs_reset;
   logic       mr_autoneg_enable;
   logic       an_link_good;
   logic       multidrop;
   logic       TX_EN;
   logic [1:0] tx_cmd_in;
   logic [1:0] tx_cmd;
   logic       hb_active;
   logic [7:0] hb_count;
   logic [1:0] hb_state;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: counts quiet cycles and remaining heartbeat cycles.
   bit         m_active;
   bit         m_gap;
   int         m_quiet_run;
   int         m_hb_left;
   int         m_count;
   logic [1:0] m_tx;
   bit         m_act;

   // Receiver-side link-status monitor fed from tx_cmd (ACTIVE_CNT = 3).
   logic [1:0]  mon_prev;
   int          mon_hb;
   pcs_status_t mon_status;

   mod_147_tx_heartbeat #(
      .HB_INTERVAL(HB_INTERVAL),
      .HB_LEN     (HB_LEN),
      .CNT_W      (16)
   ) dut (
      .TX_CLK           (TX_CLK),
      .pcs_reset        (pcs_reset),
      .mr_autoneg_enable(mr_autoneg_enable),
      .an_link_good     (an_link_good),
      .multidrop        (multidrop),
      .TX_EN            (TX_EN),
      .tx_cmd_in        (tx_cmd_in),
      .tx_cmd           (tx_cmd),
      .hb_active        (hb_active),
      .hb_count         (hb_count),
      .hb_state         (hb_state)
   );

   always #5 TX_CLK = ~TX_CLK;

   task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [1:0] model_state();
      if (!m_active)          return 2'd0;
      else if (m_gap)         return 2'd3;
      else if (m_hb_left > 0) return 2'd2;
      else                    return 2'd1;
   endfunction

   task automatic model_reset();
      m_active    = 1'b0;
      m_gap       = 1'b0;
      m_quiet_run = 0;
      m_hb_left   = 0;
      m_count     = 0;
      m_tx        = CMD_NONE;
      m_act       = 1'b0;
   endtask

   task automatic model_step();
      bit en;
      bit quiet;
      en    = mr_autoneg_enable && an_link_good && !multidrop && !pcs_reset;
      quiet = !TX_EN && (tx_cmd_in == CMD_NONE);
      m_tx  = tx_cmd_in;
      m_act = 1'b0;
      if (!en) begin
         m_active    = 1'b0;
         m_gap       = 1'b0;
         m_quiet_run = 0;
         m_hb_left   = 0;
      end else if (!m_active) begin
         m_active    = 1'b1;
         m_quiet_run = 0;
      end else if (m_gap) begin
         m_tx        = CMD_NONE;
         m_gap       = 1'b0;
         m_quiet_run = 0;
      end else if (m_hb_left > 0) begin
         if (quiet) begin
            m_tx  = CMD_HEARTBEAT;
            m_act = 1'b1;
            m_hb_left--;
            m_gap = (m_hb_left == 0);
         end else begin
            m_hb_left = 0;
         end
         m_quiet_run = 0;
      end else if (quiet) begin
         m_quiet_run++;
         if (m_quiet_run == INTERVAL) begin
            m_hb_left   = LEN;
            m_quiet_run = 0;
            if (m_count < 255) m_count++;
         end
      end else begin
         m_quiet_run = 0;
      end
   endtask

   task automatic check_all();
      check("tx_cmd",    8'(tx_cmd),    8'(m_tx));
      check("hb_active", 8'(hb_active), 8'(m_act));
      check("hb_count",  hb_count,      8'(m_count));
      check("hb_state",  8'(hb_state),  8'(model_state()));
   endtask

   task automatic cycle();
      @(posedge TX_CLK);
      model_step();
      #1;
      check_all();
      if (mon_prev == CMD_HEARTBEAT && tx_cmd != CMD_HEARTBEAT) mon_hb++;
      mon_prev   = tx_cmd;
      mon_status = (mon_hb >= 3) ? PCS_OK : PCS_NOT_OK;
   endtask

   task automatic quiet_inputs();
      TX_EN     = 1'b0;
      tx_cmd_in = CMD_NONE;
   endtask

   // Runs quiet cycles until the model has just entered SEND (bounded).
   task automatic wait_for_send(input string tag);
      int n;
      n = 0;
      quiet_inputs();
      while (!(m_active && !m_gap && m_hb_left == LEN) && n < 40) begin
         cycle();
         n++;
      end
      check(tag, 8'(hb_state), 8'(ST_SEND));
   endtask

   initial begin
      int n;
      pcs_reset         = 1'b1;
      mr_autoneg_enable = 1'b1;
      an_link_good      = 1'b1;
      multidrop         = 1'b0;
      quiet_inputs();
      model_reset();
      mon_prev   = CMD_NONE;
      mon_hb     = 0;
      mon_status = PCS_NOT_OK;

      #2;
      check("rst_tx_cmd",    8'(tx_cmd),    8'(CMD_NONE));
      check("rst_hb_active", 8'(hb_active), 8'd0);
      check("rst_hb_count",  hb_count,      8'd0);
      check("rst_hb_state",  8'(hb_state),  8'(ST_DISABLED));
      #10 pcs_reset = 1'b0;

      // Steady quiet link: heartbeats every 11 cycles.
      repeat (40) cycle();
      check("count_after_40", hb_count, 8'd3);

      // Asynchronous reset asserted mid-cycle while a heartbeat is on the wire.
      n = 0;
      while (!m_act && n < 20) begin
         cycle();
         n++;
      end
      check("hb_before_reset", 8'(hb_active), 8'd1);
      #3 pcs_reset = 1'b1;
      #1;
      model_reset();
      check("async_tx_cmd",    8'(tx_cmd),    8'(CMD_NONE));
      check("async_hb_active", 8'(hb_active), 8'd0);
      check("async_hb_count",  hb_count,      8'd0);
      check("async_hb_state",  8'(hb_state),  8'(ST_DISABLED));
      #1 pcs_reset = 1'b0;

      // Abort by TX_EN on the first SEND cycle.
      wait_for_send("reach_send_abort");
      TX_EN = 1'b1;
      cycle();
      check("abort_hb_active", 8'(hb_active), 8'd0);
      check("abort_state",     8'(hb_state),  8'(ST_WAIT));
      TX_EN = 1'b0;
      repeat (12) cycle();

      // PLCA BEACON overrides a heartbeat in progress.
      wait_for_send("reach_send_beacon");
      cycle();
      tx_cmd_in = CMD_BEACON;
      cycle();
      check("beacon_tx_cmd", 8'(tx_cmd),   8'(CMD_BEACON));
      check("beacon_state",  8'(hb_state), 8'(ST_WAIT));
      tx_cmd_in = CMD_NONE;
      repeat (12) cycle();

      // Multidrop disables heartbeats; re-enable gives the first one after 8 quiet cycles.
      multidrop = 1'b1;
      repeat (100) cycle();
      check("multidrop_state", 8'(hb_state), 8'(ST_DISABLED));
      multidrop = 1'b0;
      n = 0;
      do begin
         cycle();
         n++;
      end while (tx_cmd != CMD_HEARTBEAT && n <= 30);
      check("first_hb_cycle", 8'(n), 8'd10);

      an_link_good = 1'b0;
      repeat (100) cycle();
      check("linkdown_state", 8'(hb_state), 8'(ST_DISABLED));
      an_link_good = 1'b1;

      // Loopback to a receiver link-status monitor.
      mon_hb = 0;
      repeat (40) cycle();
      check("pcs_status_ok", 8'(mon_status), 8'(PCS_OK));

      // Random traffic, PLCA commands and enable changes.
      for (int i = 0; i < 3000; i++) begin
         TX_EN     = ($urandom_range(0, 15) == 0);
         tx_cmd_in = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(0, 2)) : CMD_NONE;
         if ($urandom_range(0, 99) == 0)  multidrop         = ~multidrop;
         if ($urandom_range(0, 99) == 0)  an_link_good      = ~an_link_good;
         if ($urandom_range(0, 149) == 0) mr_autoneg_enable = ~mr_autoneg_enable;
         cycle();
      end

      // Saturation of hb_count after 300 heartbeat periods.
      multidrop         = 1'b0;
      an_link_good      = 1'b1;
      mr_autoneg_enable = 1'b1;
      quiet_inputs();
      repeat (300 * 11 + 2) cycle();
      check("count_saturated", hb_count, 8'd255);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
